imem_boot_loader: RTL and testbench

- Sits directly upstream of the single-cycle core's instruction memory.
- Accepts a 32-bit word stream (length, program words, checksum) over a valid/ready handshake and writes each program word into instruction memory at consecutive word addresses.
- Holds the core in reset while loading; releases it only after the checksum matches.
- Makes program load a run-time operation instead of a simulation-time file preload.

---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_boot_loader_if.sv | 15 +
 rtl/imem_boot_loader_boot_csum.sv | 28 ++
 rtl/imem_boot_loader.sv | 124 ++++++++++++
 tb/tb_imem_boot_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared loader definitions: FSM state encoding, checksum seed and word stride.
// Loader and bench both import this.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_CSUM = 3'd2,
      S_RUN  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [31:0] CSUM_INIT   = 32'h0;
   localparam logic [31:0] IMEM_STRIDE = 32'd4;

   // Byte address of a program word in instruction memory.
   function automatic logic [31:0] word_addr(input logic [31:0] idx);
      return idx * IMEM_STRIDE;
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot stream (valid/ready) plus instruction-memory write port.
// slave = loader view, master = stream source / memory-side observer view.
interface imem_boot_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport slave  (input  s_valid, s_data,
                   output s_ready, imem_we, imem_addr, imem_wdata);
   modport master (output s_valid, s_data,
                   input  s_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader_boot_csum.sv
// 32-bit XOR accumulator with synchronous clear and enable; result visible the
// cycle after an enabled word, no backpressure.
module boot_csum
   import imem_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [31:0] i_data,
   output logic [31:0] o_csum
);

   logic [31:0] r_csum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_csum <= CSUM_INIT;
      end else if (i_clr) begin
         r_csum <= CSUM_INIT;
      end else if (i_en) begin
         r_csum <= r_csum ^ i_data;
      end
   end

   assign o_csum = r_csum;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams length/words/checksum into instruction memory, holding the core in reset until verified.
// Write latency 1 cycle; s_ready never drops mid-load, only in the terminal RUN/ERR states.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_boot_loader_if.slave    bus,
   output logic                 core_rst,
   output logic                 done,
   output logic                 error,
   output logic [CNT_W-1:0]     words_loaded
);

   state_t             r_state;
   state_t             w_next;
   logic               r_ready;
   logic               r_we;
   logic               r_done;
   logic               r_err;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [CNT_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_len;
   logic               w_acc;
   logic               w_ready_nxt;
   logic               w_csum_clr;
   logic               w_csum_en;
   logic [31:0]        w_csum;

   assign w_acc = bus.s_valid & r_ready;

   boot_csum u_csum (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_csum_clr),
      .i_en   (w_csum_en),
      .i_data (bus.s_data),
      .o_csum (w_csum)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_LEN;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_csum_clr  = 1'b0;
      w_csum_en   = 1'b0;
      case (r_state)
         S_LEN: begin
            w_csum_clr = w_acc;
            if (w_acc) begin
               if (bus.s_data > 32'(MAX_WORDS)) begin
                  w_next = S_ERR;
               end else if (bus.s_data == 32'd0) begin
                  w_next = S_CSUM;
               end else begin
                  w_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            w_csum_en = w_acc;
            if (w_acc && (r_idx == r_len - CNT_W'(1))) begin
               w_next = S_CSUM;
            end
         end
         S_CSUM: begin
            if (w_acc) begin
               w_next = (bus.s_data == w_csum) ? S_RUN : S_ERR;
            end
         end
         default: w_next = r_state;
      endcase
      w_ready_nxt = (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CSUM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         r_we    <= 1'b0;
         r_done  <= (w_next == S_RUN);
         r_err   <= (w_next == S_ERR);
         if (w_acc && (r_state == S_LEN)) begin
            r_len <= bus.s_data[CNT_W-1:0];
            r_idx <= '0;
         end
         // The write is registered here so the last program word lands before the checksum beat can be taken.
         if (w_csum_en) begin
            r_we    <= 1'b1;
            r_addr  <= word_addr(32'(r_idx));
            r_wdata <= bus.s_data;
            r_idx   <= r_idx + CNT_W'(1);
         end
      end
   end

   assign bus.s_ready    = r_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign core_rst       = r_done;
   assign done           = r_done;
   assign error          = r_err;
   assign words_loaded   = r_idx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed loads plus randomized loads.
// Expected writes/outcomes come from a plain list-and-XOR model of the boot stream.
module tb_imem_boot_loader;
   import imem_boot_loader_pkg::*;

   localparam int MAX_WORDS = 256;
   localparam int CNT_W     = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             core_rst;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] words_loaded;

   imem_boot_loader_if bus();

   imem_boot_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .core_rst     (core_rst),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] prog[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected write, in the cycle after its beat.
   always @(negedge clk) begin
      if (rst && bus.imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("write_addr", bus.imem_addr, w.addr);
            chk("write_data", bus.imem_wdata, w.data);
            chk("write_cycle", 32'(cyc), 32'(w.cyc));
         end
      end
   end

   task automatic send(input logic [31:0] d, output int acc_cyc, output bit ok);
      ok = 1'b0;
      acc_cyc = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: got s_ready=0 for 20 cycles expected 1");
         bus.s_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc     = cyc;
         bus.s_valid = 1'b0;
         bus.s_data  = $urandom;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
      chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
      chk({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
      chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   // Model: length beat, prog[] words at addr i*4, then the checksum; success iff the XOR of words matches.
   task automatic run_load(input string tag, input logic [31:0] len, input logic [31:0] csum,
                           input int gap_lo, input int gap_hi);
      int          acc;
      bit          ok;
      logic [31:0] x;
      bit          len_ok;
      bit          pass;
      x      = CSUM_INIT;
      len_ok = (len <= 32'(MAX_WORDS));
      send(len, acc, ok);
      if (!ok) return;
      if (!len_ok) begin
         chk({tag, "_err_after_len"}, 32'(error), 32'd1);
         pass = 1'b0;
      end else begin
         for (int i = 0; i < int'(len); i++) begin
            repeat ($urandom_range(gap_hi, gap_lo)) @(posedge clk);
            #1;
            send(prog[i], acc, ok);
            if (!ok) return;
            exp_q.push_back('{addr: 32'(i) * 32'd4, data: prog[i], cyc: acc});
            x = x ^ prog[i];
         end
         send(csum, acc, ok);
         if (!ok) return;
         pass = (csum == x);
         chk({tag, "_done_edge"}, 32'(done), 32'(pass));
         chk({tag, "_error_edge"}, 32'(error), 32'(!pass));
      end
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'(pass));
      chk({tag, "_error"}, 32'(error), 32'(!pass));
      chk({tag, "_core_rst"}, 32'(core_rst), 32'(pass));
      chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
      chk({tag, "_words_loaded"}, 32'(words_loaded), len_ok ? len : 32'd0);
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      // Beats offered in a terminal state must be ignored.
      bus.s_valid = 1'b1;
      repeat (4) begin
         bus.s_data = $urandom;
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_words_after_extra"}, 32'(words_loaded), len_ok ? len : 32'd0);
      chk({tag, "_done_after_extra"}, 32'(done), 32'(pass));
   endtask

   task automatic load_nominal();
      prog.delete();
      prog.push_back(32'h0050_0093);
      prog.push_back(32'h00A0_0113);
      prog.push_back(32'h0020_81B3);
   endtask

   initial begin
      int          acc;
      bit          ok;
      int          n;
      logic [31:0] x;
      logic [31:0] cs;

      bus.s_valid = 1'b0;
      bus.s_data  = 32'd0;
      rst         = 1'b0;
      #100;
      check_zero("in_reset");
      #50;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", 32'(bus.s_ready), 32'd1);

      load_nominal();
      run_load("nominal", 32'd3, 32'h00D0_8033, 0, 0);

      do_reset();
      run_load("bad_csum", 32'd3, 32'h0000_0000, 0, 0);

      do_reset();
      prog.delete();
      run_load("oversize", 32'd300, 32'h0, 0, 0);

      do_reset();
      run_load("empty", 32'd0, 32'h0, 0, 0);

      do_reset();
      load_nominal();
      run_load("gapped", 32'd3, 32'h00D0_8033, 2, 2);

      do_reset();
      send(32'd3, acc, ok);
      send(prog[0], acc, ok);
      if (ok) exp_q.push_back('{addr: 32'h0, data: prog[0], cyc: acc});
      send(prog[1], acc, ok);
      if (ok) exp_q.push_back('{addr: 32'h4, data: prog[1], cyc: acc});
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_zero("mid_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_load("reload", 32'd3, 32'h00D0_8033, 0, 0);

      do_reset();
      prog.delete();
      x = 32'h0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         prog.push_back($urandom);
         x = x ^ prog[i];
      end
      run_load("max_len", 32'(MAX_WORDS), x, 0, 0);

      do_reset();
      run_load("max_plus_1", 32'(MAX_WORDS + 1), 32'h0, 0, 0);

      for (int t = 0; t < 8; t++) begin
         do_reset();
         prog.delete();
         n = $urandom_range(12, 1);
         x = 32'h0;
         for (int i = 0; i < n; i++) begin
            prog.push_back($urandom);
            x = x ^ prog[i];
         end
         cs = ($urandom_range(3, 0) == 0) ? (x ^ (32'd1 << $urandom_range(31, 0))) : x;
         run_load($sformatf("rand%0d", t), 32'(n), cs, 0, 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
